// File: rtl/spi_flash_loader_if.sv
// Request bus toward the SPI controller plus the destination word-write port.
// m_req_valid is a one-cycle request with no ready: the controller always accepts, and read data
// on m_rdata is valid combinationally in the same cycle the read request is presented.
interface spi_flash_loader_if #(
  parameter int DST_AW = 16
);
  logic              m_req_valid;
  logic              m_req_write;
  logic [31:0]       m_req_addr;
  logic [31:0]       m_req_wdata;
  logic [3:0]        m_req_wstrb;
  logic [31:0]       m_rdata;
  logic              mem_we;
  logic [DST_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  modport master (
    output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb,
    input  m_rdata,
    output mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb,
    output m_rdata,
    input  mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/spi_flash_loader.sv
// Boot loader: issues a flash READ through the SPI controller register port and packs the
// returned bytes little-endian into 32-bit words written to the destination buffer.
module spi_flash_loader #(
  parameter logic [31:0] SPI_BASE = 32'h0000_0000,
  parameter logic [2:0]  CLK_DIV  = 3'd1,
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter int          DST_AW   = 16,
  parameter int          LEN_W    = 16,
  parameter int          POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       flash_addr,
  input  logic [DST_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]  byte_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state,
  spi_flash_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, CS_ON, TX, POLL, RX, CS_OFF, FIN} state_t;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TX     = 4'h8;
  localparam logic [3:0] OFF_RX     = 4'hC;
  localparam int         PW         = $clog2(POLL_MAX + 1);

  state_t            state, state_d;
  logic [23:0]       fa_q;
  logic [DST_AW-1:0] waddr_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [2:0]        hdr_q, hdr_d;
  logic [PW-1:0]     poll_q;
  logic [31:0]       pack_q, pack_d;
  logic [3:0]        strb_q, strb_d;
  logic              accept, timeout, rx_ok, hdr_phase, last_byte, flush;
  logic              req_valid_d, req_write_d;
  logic [3:0]        req_off_d;
  logic [31:0]       req_wdata_d;
  logic [7:0]        tx_byte;
  logic              unused_rdata;

  assign unused_rdata     = ^bus.m_rdata[31:8];
  assign dbg_state        = state;
  assign bus.m_req_wstrb  = 4'hF;
  assign hdr_phase        = hdr_q < 3'd4;
  assign rx_ok            = bus.m_rdata[1] && !bus.m_rdata[0];
  assign last_byte        = (cnt_q + LEN_W'(1)) == len_q;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    timeout = 1'b0;
    flush   = 1'b0;
    hdr_d   = hdr_q;
    pack_d  = pack_q;
    strb_d  = strb_q;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        hdr_d   = 3'd0;
        pack_d  = '0;
        strb_d  = '0;
        state_d = (byte_len == '0) ? FIN : CS_ON;
      end
      CS_ON:  state_d = TX;
      TX:     state_d = POLL;
      POLL: begin
        if (rx_ok) state_d = RX;
        else if (poll_q == PW'(POLL_MAX - 1)) begin
          timeout = 1'b1;
          state_d = CS_OFF;
        end
      end
      RX: begin
        if (hdr_phase) begin
          hdr_d   = hdr_q + 3'd1;
          state_d = TX;
        end else begin
          pack_d[{cnt_q[1:0], 3'b000} +: 8] = bus.m_rdata[7:0];
          strb_d[cnt_q[1:0]] = 1'b1;
          flush   = (cnt_q[1:0] == 2'd3) || last_byte;
          state_d = last_byte ? CS_OFF : TX;
        end
      end
      CS_OFF: state_d = FIN;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (hdr_d)
      3'd0:    tx_byte = READ_CMD;
      3'd1:    tx_byte = fa_q[23:16];
      3'd2:    tx_byte = fa_q[15:8];
      3'd3:    tx_byte = fa_q[7:0];
      default: tx_byte = 8'h00;
    endcase

    // The bus request belongs to the state being entered, so it is registered alongside it.
    req_valid_d = 1'b0;
    req_write_d = 1'b0;
    req_off_d   = OFF_CTRL;
    req_wdata_d = 32'h0;
    case (state_d)
      CS_ON: begin
        req_valid_d = 1'b1;
        req_write_d = 1'b1;
        req_wdata_d = 32'h100 | {28'h0, CLK_DIV, 1'b1};
      end
      TX: begin
        req_valid_d = 1'b1;
        req_write_d = 1'b1;
        req_off_d   = OFF_TX;
        req_wdata_d = {24'h0, tx_byte};
      end
      POLL: begin
        req_valid_d = 1'b1;
        req_off_d   = OFF_STATUS;
      end
      RX: begin
        req_valid_d = 1'b1;
        req_off_d   = OFF_RX;
      end
      CS_OFF: begin
        req_valid_d = 1'b1;
        req_write_d = 1'b1;
        req_wdata_d = {28'h0, CLK_DIV, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fa_q            <= '0;
      waddr_q         <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      hdr_q           <= '0;
      poll_q          <= '0;
      pack_q          <= '0;
      strb_q          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      bus.m_req_valid <= 1'b0;
      bus.m_req_write <= 1'b0;
      bus.m_req_addr  <= SPI_BASE;
      bus.m_req_wdata <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_wstrb   <= '0;
    end else begin
      state           <= state_d;
      hdr_q           <= hdr_d;
      done            <= (state == FIN);
      bus.m_req_valid <= req_valid_d;
      bus.m_req_write <= req_write_d;
      bus.m_req_addr  <= SPI_BASE + {28'h0, req_off_d};
      bus.m_req_wdata <= req_wdata_d;
      bus.mem_we      <= flush;

      if (accept)             busy <= 1'b1;
      else if (state == FIN)  busy <= 1'b0;
      if (accept)             err <= 1'b0;
      else if (timeout)       err <= 1'b1;

      if (state == TX)                 poll_q <= '0;
      else if (state == POLL && !rx_ok) poll_q <= poll_q + PW'(1);

      if (state == RX && !hdr_phase) cnt_q <= cnt_q + LEN_W'(1);

      if (flush) begin
        bus.mem_addr  <= waddr_q;
        bus.mem_wdata <= pack_d;
        bus.mem_wstrb <= strb_d;
        waddr_q       <= waddr_q + DST_AW'(1);
        pack_q        <= '0;
        strb_q        <= '0;
      end else begin
        pack_q        <= pack_d;
        strb_q        <= strb_d;
      end

      if (accept) begin
        fa_q    <= flash_addr;
        waddr_q <= dst_addr;
        len_q   <= byte_len;
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: behavioural SPI controller + flash model, expected destination
// writes queued per load and compared as the loader emits them.
module tb_spi_flash_loader;
  localparam int EXP_W = 52;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] byte_len = '0;
  logic        busy, done, err;
  logic [2:0]  dbg_state;

  spi_flash_loader_if #(.DST_AW(16)) bus ();

  spi_flash_loader #(.POLL_MAX(16)) dut (
    .clk(clk), .rst(rst), .start(start), .flash_addr(flash_addr), .dst_addr(dst_addr),
    .byte_len(byte_len), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit stall = 1'b0;

  // ---------------- SPI controller + flash model ----------------
  logic        m_en, m_cs, m_busy, m_rxv;
  logic [7:0]  m_rx;
  logic [3:0]  m_cnt;
  logic [23:0] m_fa;
  int          m_idx;
  int          m_polls = 0;
  int          m_ctrl_wr = 0;
  logic [31:0] m_last_ctrl = '0;
  logic [7:0]  mosi_q[$];

  function automatic logic [7:0] fb(input logic [23:0] a);
    logic [7:0] lo;
    lo = a[7:0] + 8'd1;
    return 8'(lo * 8'h11);
  endfunction

  assign bus.m_rdata = (bus.m_req_addr[3:0] == 4'h4) ? {30'h0, m_rxv, m_busy} :
                       (bus.m_req_addr[3:0] == 4'hC) ? {24'h0, m_rx} : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en <= 1'b0; m_cs <= 1'b0; m_busy <= 1'b0; m_rxv <= 1'b0;
      m_rx <= '0; m_cnt <= '0; m_fa <= '0; m_idx <= 0;
    end else begin
      if (m_busy) begin
        if (m_cnt == 4'd0) begin m_busy <= 1'b0; m_rxv <= 1'b1; end
        else m_cnt <= m_cnt - 4'd1;
      end
      if (bus.m_req_valid && bus.m_req_write && bus.m_req_addr[3:0] == 4'h0) begin
        m_ctrl_wr   <= m_ctrl_wr + 1;
        m_last_ctrl <= bus.m_req_wdata;
        m_en        <= bus.m_req_wdata[0] && !stall;
        m_cs        <= bus.m_req_wdata[8];
        if (bus.m_req_wdata[8] && !m_cs) m_idx <= 0;
      end
      if (bus.m_req_valid && bus.m_req_write && bus.m_req_addr[3:0] == 4'h8 && m_en && !m_busy) begin
        mosi_q.push_back(bus.m_req_wdata[7:0]);
        if (m_idx == 1) m_fa[23:16] <= bus.m_req_wdata[7:0];
        if (m_idx == 2) m_fa[15:8]  <= bus.m_req_wdata[7:0];
        if (m_idx == 3) m_fa[7:0]   <= bus.m_req_wdata[7:0];
        m_rx   <= (m_idx >= 4) ? fb(m_fa + 24'(m_idx - 4)) : 8'hFF;
        m_busy <= 1'b1;
        m_cnt  <= 4'($urandom_range(1, 6));
        m_idx  <= m_idx + 1;
      end
      if (bus.m_req_valid && !bus.m_req_write && bus.m_req_addr[3:0] == 4'h4) m_polls <= m_polls + 1;
      if (bus.m_req_valid && !bus.m_req_write && bus.m_req_addr[3:0] == 4'hC) m_rxv <= 1'b0;
    end
  end

  // ---------------- driver / scoreboard ----------------
  int n_we, n_done, n_req, done_cyc;
  logic busy_at_done;

  task automatic push_expected(input logic [23:0] fa, input logic [15:0] da, input logic [15:0] len);
    logic [31:0] w = '0;
    logic [3:0]  s = '0;
    logic [15:0] a = da;
    for (int i = 0; i < int'(len); i++) begin
      w[(i % 4) * 8 +: 8] = fb(fa + 24'(i));
      s[i % 4] = 1'b1;
      if ((i % 4) == 3 || i == int'(len) - 1) begin
        exp_q.push_back({a, s, w});
        a = a + 16'd1; w = '0; s = '0;
      end
    end
  endtask

  task automatic run_load(input logic [23:0] fa, input logic [15:0] da, input logic [15:0] len,
                          input bit mid_start);
    logic [EXP_W-1:0] exp, got;
    n_we = 0; n_done = 0; n_req = 0; done_cyc = -1; busy_at_done = 1'b1;
    @(negedge clk);
    flash_addr = fa; dst_addr = da; byte_len = len; start = 1'b1;
    for (int cyc = 0; cyc < 2000 && n_done == 0; cyc++) begin
      @(negedge clk);
      start = mid_start && cyc == 30;
      if (start) begin flash_addr = 24'hABCDEF; dst_addr = 16'h1234; byte_len = 16'd3; end
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b required 1", busy); end
      end
      if (bus.m_req_valid) n_req++;
      if (bus.mem_we) begin
        n_we++;
        checks++;
        got = {bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL mem_write_unexpected: got %h required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL mem_write: got %h required %h", got, exp); end
        end
      end
      if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
    end
    start = 1'b0;
    checks++;
    if (n_done == 0) begin errors++; $display("FAIL done_timeout: got no done required one within budget"); end
    repeat (4) begin
      @(negedge clk);
      if (done) n_done++;
      if (bus.mem_we) n_we++;
      if (bus.m_req_valid) n_req++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [124:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {bus.m_req_valid, bus.m_req_write, bus.m_req_addr, bus.m_req_wdata, bus.mem_we, bus.mem_addr,
            bus.mem_wdata, bus.mem_wstrb, busy, done, err, dbg_state};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int mb = mosi_q.size();
    int cb = m_ctrl_wr;
    logic [31:0] hdr;
    exp_q.push_back({16'h0010, 4'hF, 32'h4433_2211});
    exp_q.push_back({16'h0011, 4'hF, 32'h8877_6655});
    run_load(24'h000100, 16'h0010, 16'd8, 1'b0);
    checks++;
    if (mosi_q.size() !== mb + 12) begin
      errors++; $display("FAIL basic_mosi_count: got %0d required %0d", mosi_q.size() - mb, 12);
    end else begin
      hdr = {mosi_q[mb], mosi_q[mb+1], mosi_q[mb+2], mosi_q[mb+3]};
      checks++;
      if (hdr !== 32'h0300_0100) begin errors++; $display("FAIL basic_header: got %h required 03000100", hdr); end
    end
    checks++;
    if (n_we !== 2 || n_done !== 1) begin
      errors++; $display("FAIL basic_counts: got we=%0d done=%0d required we=2 done=1", n_we, n_done);
    end
    checks++;
    if (m_ctrl_wr - cb !== 2 || m_last_ctrl !== 32'h3) begin
      errors++; $display("FAIL basic_ctrl: got writes=%0d last=%h required writes=2 last=3", m_ctrl_wr - cb, m_last_ctrl);
    end
    checks++;
    if (err !== 1'b0 || busy_at_done !== 1'b0 || exp_q.size() !== 0) begin
      errors++; $display("FAIL basic_end: got err=%b busy=%b left=%0d required 0 0 0", err, busy_at_done, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_partial();
    exp_q.push_back({16'h0020, 4'hF, 32'h4433_2211});
    exp_q.push_back({16'h0021, 4'h1, 32'h0000_0055});
    run_load(24'h000100, 16'h0020, 16'd5, 1'b0);
    checks++;
    if (n_we !== 2 || n_done !== 1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL partial_counts: got we=%0d done=%0d left=%0d required 2 1 0", n_we, n_done, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero();
    int cb = m_ctrl_wr;
    run_load(24'h000100, 16'h0050, 16'd0, 1'b0);
    checks++;
    if (n_req !== 0 || m_ctrl_wr - cb !== 0 || n_we !== 0) begin
      errors++; $display("FAIL zero_no_traffic: got req=%0d ctrl=%0d we=%0d required 0 0 0", n_req, m_ctrl_wr - cb, n_we);
    end
    checks++;
    if (done_cyc !== 1 || n_done !== 1) begin
      errors++; $display("FAIL zero_done: got cycle=%0d count=%0d required cycle=1 count=1", done_cyc, n_done);
    end
  endtask

  task automatic test_timeout();
    int pb = m_polls;
    int cb = m_ctrl_wr;
    stall = 1'b1;
    run_load(24'h000100, 16'h0030, 16'd4, 1'b0);
    stall = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b required 1", err); end
    checks++;
    if (m_polls - pb !== 16) begin errors++; $display("FAIL timeout_polls: got %0d required 16", m_polls - pb); end
    checks++;
    if (m_ctrl_wr - cb !== 2 || m_last_ctrl !== 32'h3) begin
      errors++; $display("FAIL timeout_ctrl: got writes=%0d last=%h required writes=2 last=3", m_ctrl_wr - cb, m_last_ctrl);
    end
    checks++;
    if (n_we !== 0 || n_done !== 1) begin
      errors++; $display("FAIL timeout_counts: got we=%0d done=%0d required 0 1", n_we, n_done);
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back({16'hFFFF, 4'hF, 32'h4433_2211});
    exp_q.push_back({16'h0000, 4'hF, 32'h8877_6655});
    run_load(24'h000200, 16'hFFFF, 16'd8, 1'b1);
    checks++;
    if (n_we !== 2 || n_done !== 1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL wrap_counts: got we=%0d done=%0d left=%0d required 2 1 0", n_we, n_done, exp_q.size());
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b required 0", err); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [23:0] fa;
    logic [15:0] da, len;
    logic [31:0] hdr;
    int mb;
    for (int it = 0; it < 4; it++) begin
      fa  = (it == 0) ? 24'hFFFFFF : 24'($urandom());
      da  = 16'($urandom());
      len = 16'($urandom_range(1, 11));
      mb  = mosi_q.size();
      push_expected(fa, da, len);
      run_load(fa, da, len, 1'b0);
      checks++;
      if (mosi_q.size() < mb + 4) begin
        errors++; $display("FAIL b2b_mosi_count: got %0d required %0d", mosi_q.size() - mb, 4 + int'(len));
      end else begin
        hdr = {mosi_q[mb], mosi_q[mb+1], mosi_q[mb+2], mosi_q[mb+3]};
        checks++;
        if (hdr !== {8'h03, fa}) begin errors++; $display("FAIL b2b_header: got %h required %h", hdr, {8'h03, fa}); end
      end
      checks++;
      if (n_done !== 1 || exp_q.size() !== 0) begin
        errors++; $display("FAIL b2b_end: got done=%0d left=%0d required 1 0", n_done, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [124:0] outs;
    int w = 0, d = 0, r = 0;
    @(negedge clk);
    flash_addr = 24'h000100; dst_addr = 16'h0040; byte_len = 16'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {bus.m_req_valid, bus.m_req_write, bus.m_req_addr, bus.m_req_wdata, bus.mem_we, bus.mem_addr,
            bus.mem_wdata, bus.mem_wstrb, busy, done, err, dbg_state};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h required 0", outs); end
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.mem_we) w++;
      if (done) d++;
      if (bus.m_req_valid) r++;
    end
    checks++;
    if (w !== 0 || d !== 0 || r !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: got we=%0d done=%0d req=%0d required 0 0 0", w, d, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_zero();
    test_timeout();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_basic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
